// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, long-latency scoreboard,
// outstanding-op limit and a multi-cycle branch flush sequencer.
module hazard_ctrl #(
  parameter int NREGS        = 32,
  parameter int MAX_OUTST    = 4,
  parameter int FLUSH_CYCLES = 2,
  localparam int RW = $clog2(NREGS),
  localparam int CW = $clog2(MAX_OUTST + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_id_valid,
  input  logic [RW-1:0] i_id_rs1,
  input  logic [RW-1:0] i_id_rs2,
  input  logic [RW-1:0] i_id_rd,
  input  logic          i_id_we,
  input  logic          i_id_long,
  input  logic [RW-1:0] i_ex_rs1,
  input  logic [RW-1:0] i_ex_rs2,
  input  logic [RW-1:0] i_mem_rd,
  input  logic          i_mem_we,
  input  logic [RW-1:0] i_wb_rd,
  input  logic          i_wb_we,
  input  logic          i_lw_valid,
  input  logic [RW-1:0] i_lw_rd,
  input  logic          i_branch,
  output logic [1:0]    o_fwd_a,
  output logic [1:0]    o_fwd_b,
  output logic          o_stall,
  output logic          o_issue,
  output logic          o_flush_if_id,
  output logic          o_flush_id_ex,
  output logic [CW-1:0] o_outst,
  output logic          o_sb_err
);

  localparam logic [1:0] FWD_NONE   = 2'b00;
  localparam logic [1:0] FWD_EX_MEM = 2'b01;
  localparam logic [1:0] FWD_MEM_WB = 2'b10;

  typedef enum logic {IDLE, FLUSH} fstate_t;

  fstate_t       state, state_nx;
  logic [3:0]    fcnt, fcnt_nx;
  logic [NREGS-1:0] pend, pend_nx;
  logic [CW-1:0] outst, outst_nx;
  logic          err;
  logic          flush_active, hazard, set_long, lw_hit, lw_err, inc, dec;

  function automatic logic [1:0] fwd_sel(input logic [RW-1:0] rs,
                                         input logic [RW-1:0] mrd, input logic mwe,
                                         input logic [RW-1:0] wrd, input logic wwe);
    if (mwe && mrd != '0 && mrd == rs)      return FWD_EX_MEM;
    else if (wwe && wrd != '0 && wrd == rs) return FWD_MEM_WB;
    else                                    return FWD_NONE;
  endfunction

  assign o_fwd_a = fwd_sel(i_ex_rs1, i_mem_rd, i_mem_we, i_wb_rd, i_wb_we);
  assign o_fwd_b = fwd_sel(i_ex_rs2, i_mem_rd, i_mem_we, i_wb_rd, i_wb_we);

  // A resolving branch flushes in the same cycle; the FSM holds it afterwards.
  assign flush_active  = i_rst && (i_branch || state == FLUSH);
  assign o_flush_if_id = flush_active;
  assign o_flush_id_ex = flush_active;

  assign hazard = i_id_valid && (pend[i_id_rs1] || pend[i_id_rs2] ||
                                 (i_id_we && pend[i_id_rd]) ||
                                 (i_id_long && outst == CW'(MAX_OUTST)));
  assign o_stall = i_rst && !flush_active && hazard;
  assign o_issue = i_rst && i_id_valid && !hazard && !flush_active;

  assign set_long = o_issue && i_id_we && i_id_long && i_id_rd != '0;
  assign lw_hit   = i_lw_valid && pend[i_lw_rd];
  assign lw_err   = i_lw_valid && (!lw_hit || outst == '0);
  assign inc      = set_long && outst != CW'(MAX_OUTST);
  assign dec      = lw_hit && outst != '0;

  always_comb begin
    state_nx = state;
    fcnt_nx  = fcnt;
    if (i_branch) begin
      state_nx = FLUSH;
      fcnt_nx  = 4'(FLUSH_CYCLES);
    end else if (state == FLUSH) begin
      if (fcnt <= 4'd1) begin
        state_nx = IDLE;
        fcnt_nx  = '0;
      end else begin
        fcnt_nx = fcnt - 4'd1;
      end
    end
  end

  // Set is applied after clear so a same-register collision leaves it pending.
  always_comb begin
    pend_nx = pend;
    if (lw_hit)   pend_nx[i_lw_rd] = 1'b0;
    if (set_long) pend_nx[i_id_rd] = 1'b1;
    pend_nx[0] = 1'b0;
    outst_nx = outst;
    case ({inc, dec})
      2'b10:   outst_nx = outst + CW'(1);
      2'b01:   outst_nx = outst - CW'(1);
      default: outst_nx = outst;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= IDLE;
      fcnt  <= '0;
      pend  <= '0;
      outst <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      fcnt  <= fcnt_nx;
      pend  <= pend_nx;
      outst <= outst_nx;
      err   <= err | lw_err;
    end
  end

  assign o_outst  = outst;
  assign o_sb_err = err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: driver pushes expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_hazard_ctrl;
  localparam int RW = 5;
  localparam int CW = 3;
  localparam logic [1:0] NON = 2'b00, EXM = 2'b01, MWB = 2'b10;

  logic clk = 1'b0;
  logic rst;
  logic idv, we, lng, mwe, wwe, lwv, br;
  logic [RW-1:0] rs1, rs2, rd, exrs1, exrs2, mrd, wrd, lwrd;
  logic [1:0] fa, fb;
  logic stall, issue, fl1, fl2, err;
  logic [CW-1:0] outst;

  typedef struct {
    int         id;
    logic       st, is, fl, er;
    int         os;
    logic [1:0] fa, fb;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int vid = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_id_valid(idv), .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_rd(rd), .i_id_we(we), .i_id_long(lng), .i_ex_rs1(exrs1), .i_ex_rs2(exrs2),
    .i_mem_rd(mrd), .i_mem_we(mwe), .i_wb_rd(wrd), .i_wb_we(wwe), .i_lw_valid(lwv),
    .i_lw_rd(lwrd), .i_branch(br), .o_fwd_a(fa), .o_fwd_b(fb), .o_stall(stall),
    .o_issue(issue), .o_flush_if_id(fl1), .o_flush_id_ex(fl2), .o_outst(outst),
    .o_sb_err(err)
  );

  task automatic clr();
    rst = 1'b1; idv = 0; we = 0; lng = 0; mwe = 0; wwe = 0; lwv = 0; br = 0;
    rs1 = '0; rs2 = '0; rd = '0; exrs1 = '0; exrs2 = '0; mrd = '0; wrd = '0; lwrd = '0;
  endtask

  // Push the expectation for the cycle whose inputs are already driven.
  task automatic v(input logic st, input logic is, input logic fl, input int os,
                   input logic er, input logic [1:0] ea = NON, input logic [1:0] eb = NON);
    exp_t e;
    e.id = vid; e.st = st; e.is = is; e.fl = fl; e.os = os; e.er = er; e.fa = ea; e.fb = eb;
    q.push_back(e);
    vid++;
    @(posedge clk); #1;
    clr();
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (stall !== e.st || issue !== e.is || fl1 !== e.fl || fl2 !== e.fl ||
          int'(outst) != e.os || err !== e.er || fa !== e.fa || fb !== e.fb) begin
        errors++;
        $display("FAIL vec%0d got stall=%b issue=%b fl=%b%b outst=%0d err=%b fa=%0d fb=%0d want stall=%b issue=%b fl=%b outst=%0d err=%b fa=%0d fb=%0d",
                 e.id, stall, issue, fl1, fl2, outst, err, fa, fb,
                 e.st, e.is, e.fl, e.os, e.er, e.fa, e.fb);
      end
    end
  end

  initial begin
    clr();
    rst = 0; @(posedge clk); #1;
    // reset state
    rst = 0; idv = 1; v(0, 0, 0, 0, 0);
    // RAW on a long-latency writer
    idv = 1; rd = 5; we = 1; lng = 1;          v(0, 1, 0, 0, 0);
    idv = 1; rs1 = 5;                          v(1, 0, 0, 1, 0);
    idv = 1; rs2 = 5;                          v(1, 0, 0, 1, 0);
    idv = 1; rs1 = 5; lwv = 1; lwrd = 5;       v(1, 0, 0, 1, 0);
    idv = 1; rs1 = 5;                          v(0, 1, 0, 0, 0);
    // forwarding
    exrs1 = 7; exrs2 = 7; mwe = 1; mrd = 7; wwe = 1; wrd = 7; v(0, 0, 0, 0, 0, EXM, EXM);
    exrs1 = 7; exrs2 = 8; mwe = 1; mrd = 8; wwe = 1; wrd = 7; v(0, 0, 0, 0, 0, MWB, EXM);
    mwe = 1; wwe = 1;                          v(0, 0, 0, 0, 0, NON, NON);
    exrs1 = 7; exrs2 = 7; mrd = 7; wrd = 7;    v(0, 0, 0, 0, 0, NON, NON);
    // outstanding limit
    for (int k = 1; k <= 4; k++) begin
      idv = 1; rd = RW'(k); we = 1; lng = 1;   v(0, 1, 0, k - 1, 0);
    end
    idv = 1; rd = 9; we = 1; lng = 1;          v(1, 0, 0, 4, 0);
    idv = 1; rd = 9; we = 1; lng = 1; lwv = 1; lwrd = 2; v(1, 0, 0, 4, 0);
    idv = 1; rd = 9; we = 1; lng = 1;          v(0, 1, 0, 3, 0);
    v(0, 0, 0, 4, 0);
    lwv = 1; lwrd = 1; v(0, 0, 0, 4, 0);
    lwv = 1; lwrd = 3; v(0, 0, 0, 3, 0);
    lwv = 1; lwrd = 4; v(0, 0, 0, 2, 0);
    lwv = 1; lwrd = 9; v(0, 0, 0, 1, 0);
    v(0, 0, 0, 0, 0);
    // single branch pulse; flushed long to x6 must not become pending
    br = 1; idv = 1; rd = 6; we = 1; lng = 1;  v(0, 0, 1, 0, 0);
    idv = 1; rs1 = 6;                          v(0, 0, 1, 0, 0);
    idv = 1; rs1 = 6;                          v(0, 0, 1, 0, 0);
    idv = 1; rs1 = 6;                          v(0, 1, 0, 0, 0);
    // back-to-back branches with x5 pending
    idv = 1; rd = 5; we = 1; lng = 1;          v(0, 1, 0, 0, 0);
    br = 1; idv = 1; rs1 = 5;                  v(0, 0, 1, 1, 0);
    br = 1; idv = 1; rs1 = 5;                  v(0, 0, 1, 1, 0);
    idv = 1; rs1 = 5;                          v(0, 0, 1, 1, 0);
    idv = 1; rs1 = 5;                          v(0, 0, 1, 1, 0);
    idv = 1; rs1 = 5;                          v(1, 0, 0, 1, 0);
    lwv = 1; lwrd = 5;                         v(0, 0, 0, 1, 0);
    v(0, 0, 0, 0, 0);
    // completion to a non-pending register: sticky error
    lwv = 1; lwrd = 11;                        v(0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 1);
    v(0, 0, 0, 0, 1);
    // same-cycle issue and completion to x3 (not pending): set wins
    idv = 1; rd = 3; we = 1; lng = 1; lwv = 1; lwrd = 3; v(0, 1, 0, 0, 1);
    idv = 1; rs1 = 3;                          v(1, 0, 0, 1, 1);
    // reset mid-flush clears everything
    br = 1;                                    v(0, 0, 1, 1, 1);
    rst = 0; idv = 1; rs1 = 3;                 v(0, 0, 0, 1, 1);
    idv = 1; rs1 = 3;                          v(0, 1, 0, 0, 0);
    v(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
